// File: rtl/mem_fill_if.sv
`default_nettype none
// ============================================================================
// mem_fill_if : request, fill-return and memory-port signals of mem_fill_ctrl
// Rev 1.0
// ============================================================================
interface mem_fill_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int WORDS      = 8
);
  localparam int IDX_W = $clog2(WORDS);

  logic                  req_ready;
  logic                  miss_req;
  logic [ADDR_WIDTH-1:0] miss_addr;
  logic                  wr_req;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [15:0]           wr_data;
  logic                  fill_we;
  logic [IDX_W-1:0]      fill_word_idx;
  logic [15:0]           fill_data;
  logic                  fill_done;
  logic                  wr_done;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [15:0]           mem_wdata;
  logic                  mem_enable;
  logic                  mem_wr;
  logic [15:0]           mem_rdata;

  modport master (
    output req_ready, fill_we, fill_word_idx, fill_data, fill_done, wr_done,
           mem_addr, mem_wdata, mem_enable, mem_wr,
    input  miss_req, miss_addr, wr_req, wr_addr, wr_data, mem_rdata
  );

  modport slave (
    input  req_ready, fill_we, fill_word_idx, fill_data, fill_done, wr_done,
           mem_addr, mem_wdata, mem_enable, mem_wr,
    output miss_req, miss_addr, wr_req, wr_addr, wr_data, mem_rdata
  );
endinterface
`default_nettype wire

// File: rtl/mem_fill_ctrl.sv
`default_nettype none
// ============================================================================
// mem_fill_ctrl : cache-side requester for block fills and write-through stores
// Rev 1.0
// ============================================================================
module mem_fill_ctrl #(
  parameter int ADDR_WIDTH = 16,
  parameter int WORDS      = 8
) (
  input  wire logic   clk,
  input  wire logic   rst_n,
  mem_fill_if.master  bus
);
  localparam int IDX_W = $clog2(WORDS);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_FILL  = 2'd2;

  localparam logic [ADDR_WIDTH-1:0] C_HALF_MASK  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] C_BLOCK_MASK = ADDR_WIDTH'(2*WORDS-1);
  localparam logic [IDX_W-1:0]      C_LAST_IDX   = IDX_W'(WORDS-1);

  logic [1:0]            state_q,     state_d;
  logic [IDX_W-1:0]      cnt_q,       cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q,      addr_d;
  logic [15:0]           wdata_q,     wdata_d;
  logic                  fill_we_q,   fill_we_d;
  logic [IDX_W-1:0]      fill_idx_q,  fill_idx_d;
  logic [15:0]           fill_data_q, fill_data_d;
  logic                  fill_done_q, fill_done_d;
  logic                  wr_done_q,   wr_done_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      fill_we_q   <= 1'b0;
      fill_idx_q  <= '0;
      fill_data_q <= '0;
      fill_done_q <= 1'b0;
      wr_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      fill_we_q   <= fill_we_d;
      fill_idx_q  <= fill_idx_d;
      fill_data_q <= fill_data_d;
      fill_done_q <= fill_done_d;
      wr_done_q   <= wr_done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    fill_we_d   = 1'b0;
    fill_idx_d  = fill_idx_q;
    fill_data_d = fill_data_q;
    fill_done_d = 1'b0;
    wr_done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Store wins so it lands in memory before any fill of the same block.
        if (bus.wr_req) begin
          addr_d  = bus.wr_addr & ~C_HALF_MASK;
          wdata_d = bus.wr_data;
          state_d = S_WRITE;
        end else if (bus.miss_req) begin
          addr_d  = bus.miss_addr & ~C_BLOCK_MASK;
          cnt_d   = '0;
          state_d = S_FILL;
        end
      end
      S_WRITE: begin
        wr_done_d = 1'b1;
        state_d   = S_IDLE;
      end
      S_FILL: begin
        fill_we_d   = 1'b1;
        fill_idx_d  = cnt_q;
        fill_data_d = bus.mem_rdata;
        cnt_d       = cnt_q + IDX_W'(1);
        if (cnt_q == C_LAST_IDX) begin
          fill_done_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Memory port is a pure decode of registered state, never of request inputs.
  always_comb begin
    bus.req_ready  = (state_q == S_IDLE);
    bus.mem_enable = 1'b0;
    bus.mem_wr     = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_wdata  = '0;
    case (state_q)
      S_WRITE: begin
        bus.mem_enable = 1'b1;
        bus.mem_wr     = 1'b1;
        bus.mem_addr   = addr_q;
        bus.mem_wdata  = wdata_q;
      end
      S_FILL: begin
        bus.mem_enable = 1'b1;
        bus.mem_addr   = addr_q + ADDR_WIDTH'({cnt_q, 1'b0});
      end
      default: ;
    endcase
  end

  assign bus.fill_we       = fill_we_q;
  assign bus.fill_word_idx = fill_idx_q;
  assign bus.fill_data     = fill_data_q;
  assign bus.fill_done     = fill_done_q;
  assign bus.wr_done       = wr_done_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_fill_ctrl.sv
`default_nettype none
// ============================================================================
// tb_mem_fill_ctrl : directed bench for mem_fill_ctrl with a 64 KiB memory model
// Rev 1.0
// ============================================================================
module tb_mem_fill_ctrl;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  logic [15:0] mem [0:32767];
  logic [15:0] got [0:7];

  mem_fill_if #(.ADDR_WIDTH(16), .WORDS(8)) bus ();

  mem_fill_ctrl #(.ADDR_WIDTH(16), .WORDS(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  assign bus.mem_rdata = mem[bus.mem_addr[15:1]];

  always @(posedge clk)
    if (bus.mem_enable && bus.mem_wr) mem[bus.mem_addr[15:1]] <= bus.mem_wdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Starts at the first cycle after the miss was accepted; runs 9 cycles.
  task automatic fill_body(input logic [15:0] base, input bit busy);
    logic [15:0] ea;
    logic [15:0] wi;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (c <= 8) begin
        ea = base + 16'(2 * (c - 1));
        chk("rd_en",    32'(bus.mem_enable), 32'd1);
        chk("rd_wr",    32'(bus.mem_wr),     32'd0);
        chk("rd_addr",  32'(bus.mem_addr),   32'(ea));
        chk("rd_ready", 32'(bus.req_ready),  32'd0);
      end else begin
        chk("end_en",    32'(bus.mem_enable), 32'd0);
        chk("end_ready", 32'(bus.req_ready),  32'd1);
      end
      chk("fill_we",   32'(bus.fill_we),   (c >= 2) ? 32'd1 : 32'd0);
      chk("fill_done", 32'(bus.fill_done), (c == 9) ? 32'd1 : 32'd0);
      if (c >= 2) begin
        wi = (base >> 1) + 16'(c - 2);
        chk("fill_idx",  32'(bus.fill_word_idx), 32'(c - 2));
        chk("fill_data", 32'(bus.fill_data),     32'(mem[wi]));
        got[c-2] = bus.fill_data;
      end
      if (c == 1) bus.miss_req = 1'b0;
      if (busy && c >= 2 && c <= 7) begin
        bus.miss_req  = c[0];
        bus.miss_addr = 16'h2000 + 16'(2 * c);
        bus.wr_req    = ~c[0];
        bus.wr_addr   = 16'h3000;
        bus.wr_data   = 16'hDEAD;
      end
      if (busy && c == 8) begin
        bus.miss_req = 1'b0;
        bus.wr_req   = 1'b0;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32768; i++) mem[i] = 16'(i) ^ 16'h5A5A;
    for (int i = 0; i < 8; i++) mem[16'h0918 + i] = 16'hA000 + 16'(i);
    bus.miss_req  = 1'b0;
    bus.miss_addr = '0;
    bus.wr_req    = 1'b0;
    bus.wr_addr   = '0;
    bus.wr_data   = '0;

    // Reset state
    @(negedge clk);
    chk("rst_ready",     32'(bus.req_ready),  32'd1);
    chk("rst_en",        32'(bus.mem_enable), 32'd0);
    chk("rst_wr",        32'(bus.mem_wr),     32'd0);
    chk("rst_addr",      32'(bus.mem_addr),   32'd0);
    chk("rst_fill_we",   32'(bus.fill_we),    32'd0);
    chk("rst_fill_data", 32'(bus.fill_data),  32'd0);
    chk("rst_fill_done", 32'(bus.fill_done),  32'd0);
    chk("rst_wr_done",   32'(bus.wr_done),    32'd0);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("idle_en",    32'(bus.mem_enable), 32'd0);
      chk("idle_ready", 32'(bus.req_ready),  32'd1);
    end

    // Block fill from an unaligned miss address
    bus.miss_req  = 1'b1;
    bus.miss_addr = 16'h1236;
    fill_body(16'h1230, 1'b0);
    chk("fill_w0", 32'(got[0]), 32'h0000_A000);
    chk("fill_w7", 32'(got[7]), 32'h0000_A007);

    // Write-through with odd address, then read it back by a fill
    bus.wr_req  = 1'b1;
    bus.wr_addr = 16'h0041;
    bus.wr_data = 16'hBEEF;
    @(negedge clk);
    chk("wr_en",      32'(bus.mem_enable), 32'd1);
    chk("wr_wr",      32'(bus.mem_wr),     32'd1);
    chk("wr_addr",    32'(bus.mem_addr),   32'h0000_0040);
    chk("wr_wdata",   32'(bus.mem_wdata),  32'h0000_BEEF);
    chk("wr_done_c1", 32'(bus.wr_done),    32'd0);
    bus.wr_req = 1'b0;
    @(negedge clk);
    chk("wr_done_c2", 32'(bus.wr_done),    32'd1);
    chk("wr_ready",   32'(bus.req_ready),  32'd1);
    chk("wr_idle_en", 32'(bus.mem_enable), 32'd0);
    @(negedge clk);
    chk("wr_done_c3", 32'(bus.wr_done),    32'd0);
    bus.miss_req  = 1'b1;
    bus.miss_addr = 16'h0040;
    fill_body(16'h0040, 1'b0);
    chk("wb_idx0", 32'(got[0]), 32'h0000_BEEF);

    // Simultaneous write and miss: write first, miss on returning ready
    bus.wr_req    = 1'b1;
    bus.wr_addr   = 16'h1232;
    bus.wr_data   = 16'h5555;
    bus.miss_req  = 1'b1;
    bus.miss_addr = 16'h1230;
    @(negedge clk);
    chk("sim_wr",    32'(bus.mem_wr),   32'd1);
    chk("sim_addr",  32'(bus.mem_addr), 32'h0000_1232);
    chk("sim_wdata", 32'(bus.mem_wdata), 32'h0000_5555);
    bus.wr_req = 1'b0;
    @(negedge clk);
    chk("sim_ready",   32'(bus.req_ready),  32'd1);
    chk("sim_en_gap",  32'(bus.mem_enable), 32'd0);
    chk("sim_wr_done", 32'(bus.wr_done),    32'd1);
    fill_body(16'h1230, 1'b0);
    chk("sim_idx0", 32'(got[0]), 32'h0000_A000);
    chk("sim_idx1", 32'(got[1]), 32'h0000_5555);
    chk("sim_idx2", 32'(got[2]), 32'h0000_A002);

    // Reset in the middle of a fill
    bus.miss_req  = 1'b1;
    bus.miss_addr = 16'h1230;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 1) bus.miss_req = 1'b0;
    end
    chk("ab_addr_cnt3", 32'(bus.mem_addr),      32'h0000_1236);
    chk("ab_idx_pre",   32'(bus.fill_word_idx), 32'd2);
    #1 rst_n = 1'b0;
    #1;
    chk("ab_en",        32'(bus.mem_enable), 32'd0);
    chk("ab_addr",      32'(bus.mem_addr),   32'd0);
    chk("ab_fill_we",   32'(bus.fill_we),    32'd0);
    chk("ab_ready",     32'(bus.req_ready),  32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("ab_post_en",   32'(bus.mem_enable), 32'd0);
      chk("ab_post_we",   32'(bus.fill_we),    32'd0);
      chk("ab_post_done", 32'(bus.fill_done),  32'd0);
    end
    bus.miss_req  = 1'b1;
    bus.miss_addr = 16'h123E;
    fill_body(16'h1230, 1'b0);

    // Requests toggled while busy are ignored
    bus.miss_req  = 1'b1;
    bus.miss_addr = 16'h1236;
    fill_body(16'h1230, 1'b1);
    repeat (3) begin
      @(negedge clk);
      chk("busy_post_en", 32'(bus.mem_enable), 32'd0);
      chk("busy_post_we", 32'(bus.fill_we),    32'd0);
      chk("busy_post_wd", 32'(bus.wr_done),    32'd0);
    end
    chk("busy_no_store", 32'(mem[16'h1800]), 32'(16'h1800 ^ 16'h5A5A));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
